// File: rtl/rv32_mem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, master IDs, halt address default.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef logic mid_t;

  localparam mid_t MID_CORE   = 1'b0;
  localparam mid_t MID_LOADER = 1'b1;

  localparam int unsigned HALT_ADDR_DEFAULT = 7777;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: on a tie the master not granted last wins.
module dmem_rr_pick
  import rv32_mem_pkg::*;
(
  input  logic [1:0] valid,
  input  mid_t       last_grant,
  output mid_t       grant
);

  always_comb begin
    grant = MID_CORE;
    if (valid == 2'b11) begin
      grant = mid_t'(~last_grant);
    end else if (valid[1]) begin
      grant = MID_LOADER;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: one transaction in flight, accept -> issue -> respond.
module dmem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned HALT_ADDR = HALT_ADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                m0_valid,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_ready,
  output logic                m0_resp,
  output logic [DATA_W-1:0]   m0_rdata,

  input  logic                m1_valid,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_ready,
  output logic                m1_resp,
  output logic [DATA_W-1:0]   m1_rdata,

  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                halt
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_t              r_state;
  mid_t                r_last_grant;
  mid_t                r_id;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic                r_halt;

  mid_t                w_grant;
  logic                w_accept;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [BE_W-1:0]     w_be;
  logic                w_resp;
  logic [DATA_W-1:0]   w_rdata;

  dmem_rr_pick u_pick (
    .valid      ({m1_valid, m0_valid}),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  assign w_accept = (r_state == ST_IDLE) && (m0_valid || m1_valid);

  assign w_we    = (w_grant == MID_LOADER) ? m1_we    : m0_we;
  assign w_addr  = (w_grant == MID_LOADER) ? m1_addr  : m0_addr;
  assign w_wdata = (w_grant == MID_LOADER) ? m1_wdata : m0_wdata;
  assign w_be    = (w_grant == MID_LOADER) ? m1_be    : m0_be;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= MID_LOADER;
      r_id         <= MID_CORE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_halt       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state      <= ST_ISSUE;
            r_last_grant <= w_grant;
            r_id         <= w_grant;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_be         <= w_be;
            // Set on the accept edge so halt is already high throughout ISSUE.
            if (w_we && (w_addr == ADDR_W'(HALT_ADDR))) begin
              r_halt <= 1'b1;
            end
          end
        end
        ST_ISSUE: r_state <= ST_RESP;
        ST_RESP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign m0_ready = w_accept && (w_grant == MID_CORE);
  assign m1_ready = w_accept && (w_grant == MID_LOADER);

  assign mem_en    = (r_state == ST_ISSUE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;

  // Memory read data is valid during RESP; writes respond with zero.
  assign w_resp  = (r_state == ST_RESP);
  assign w_rdata = (w_resp && !r_we) ? mem_rdata : '0;

  assign m0_resp  = w_resp && (r_id == MID_CORE);
  assign m1_resp  = w_resp && (r_id == MID_LOADER);
  assign m0_rdata = (r_id == MID_CORE)   ? w_rdata : '0;
  assign m1_rdata = (r_id == MID_LOADER) ? w_rdata : '0;

  assign halt = r_halt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model checked every cycle, directed and random traffic.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned HA = 7777;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          m0_valid, m0_we, m0_ready, m0_resp;
  logic [31:0]   m0_addr, m0_wdata, m0_rdata;
  logic [3:0]    m0_be;
  logic          m1_valid, m1_we, m1_ready, m1_resp;
  logic [31:0]   m1_addr, m1_wdata, m1_rdata;
  logic [3:0]    m1_be;
  logic          mem_en, mem_we, halt;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata = 32'h0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HALT_ADDR(HA)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_ready(m0_ready), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_ready(m1_ready), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .halt(halt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Memory behind the arbiter: read data registered, valid the cycle after mem_en.
  logic [31:0] emem [logic [31:0]];
  initial forever begin
    logic [31:0] w;
    @(posedge clk);
    if (mem_en) begin
      w = emem.exists(mem_addr) ? emem[mem_addr] : 32'h0;
      mem_rdata <= w;
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        emem[mem_addr] = w;
      end
    end
  end

  // Reference model: transaction-level view with a countdown since the last accept.
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          id;
  } txn_t;

  logic [31:0] mmem [logic [31:0]];
  int   busy;
  bit   lastg;
  bit   mhalt;
  txn_t cur;
  bit   acc0, acc1;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : 32'h0;
  endfunction

  initial forever begin
    bit win, e_r0, e_r1;
    logic [31:0] w;
    @(negedge clk);
    acc0 = m0_ready;
    acc1 = m1_ready;
    if (reset) begin
      chk("rst_ready0", m0_ready, 0);
      chk("rst_ready1", m1_ready, 0);
      chk("rst_resp0", m0_resp, 0);
      chk("rst_resp1", m1_resp, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_halt", halt, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rdata0", m0_rdata, 0);
      chk("rst_rdata1", m1_rdata, 0);
      busy  = 0;
      lastg = 1;
      mhalt = 0;
      cur   = '{we: 0, addr: 0, wdata: 0, be: 0, id: 0};
    end else begin
      if (m0_valid && m1_valid) win = !lastg;
      else                      win = m1_valid;
      e_r0 = (busy == 0) && m0_valid && !win;
      e_r1 = (busy == 0) && m1_valid && win;
      chk("ready0", m0_ready, e_r0);
      chk("ready1", m1_ready, e_r1);
      chk("mem_en", mem_en, busy == 2);
      chk("mem_we", mem_we, cur.we);
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_wdata", mem_wdata, cur.wdata);
      chk("mem_be", mem_be, cur.be);
      chk("resp0", m0_resp, busy == 1 && cur.id == 0);
      chk("resp1", m1_resp, busy == 1 && cur.id == 1);
      if (busy == 1) begin
        if (cur.id == 0) chk("rdata0", m0_rdata, cur.we ? 32'h0 : mrd(cur.addr));
        else             chk("rdata1", m1_rdata, cur.we ? 32'h0 : mrd(cur.addr));
      end
      chk("halt", halt, mhalt);
      if (busy == 2 && cur.we) begin
        w = mrd(cur.addr);
        for (int b = 0; b < 4; b++) if (cur.be[b]) w[8*b +: 8] = cur.wdata[8*b +: 8];
        mmem[cur.addr] = w;
      end
      if (busy > 0) busy--;
      else if (e_r0 || e_r1) begin
        if (win) cur = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be, id: 1};
        else     cur = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be, id: 0};
        lastg = win;
        busy  = 2;
        if (cur.we && cur.addr == HA) mhalt = 1;
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1;
    m0_valid = 0;
    m1_valid = 0;
    repeat (n) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic set_req(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    if (m == 0) begin
      m0_valid = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be;
    end else begin
      m1_valid = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the response.
  task automatic run_txn(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd, output int lat,
                         output logic h_issue);
    int k;
    bit got;
    set_req(m, we, a, d, be);
    k = 0; got = 0;
    while (!got && k < 50) begin
      @(negedge clk); k++;
      got = (m == 0) ? m0_ready : m1_ready;
    end
    if (!got) chk("txn_accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (m == 0) m0_valid = 0; else m1_valid = 0;
    lat = 0; got = 0; rd = 'x; h_issue = 'x;
    while (!got && lat < 10) begin
      @(negedge clk); lat++;
      if (lat == 1) h_issue = halt;
      got = (m == 0) ? m0_resp : m1_resp;
      rd  = (m == 0) ? m0_rdata : m1_rdata;
    end
    if (!got) chk("txn_resp_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic rand_req(input int m);
    logic [31:0] a;
    a = ($urandom_range(0, 15) == 0) ? HA : 32'h100 + 4 * $urandom_range(0, 7);
    set_req(m, $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    logic [31:0] rd;
    int          lat, k;
    logic        h;
    int          order[$];
    int          exp39[6] = '{0, 1, 0, 1, 0, 1};
    bit          pend0, pend1;
    int          rst_cnt;

    reset = 1;
    m0_valid = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
    m1_valid = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
    emem[32'h10] = 32'hDEADBEEF; mmem[32'h10] = 32'hDEADBEEF;
    emem[32'h20] = 32'h11223344; mmem[32'h20] = 32'h11223344;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Round-robin under a continuous tie, starting from reset.
    set_req(0, 0, 32'h100, 0, 4'hF);
    set_req(1, 0, 32'h104, 0, 4'hF);
    k = 0;
    while (order.size() < 6 && k < 40) begin
      @(negedge clk); k++;
      if (m0_ready) order.push_back(0);
      if (m1_ready) order.push_back(1);
    end
    @(posedge clk); #1;
    m0_valid = 0; m1_valid = 0;
    chk("rr_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("rr_order", order[i], exp39[i]);

    // First accept in the first IDLE cycle after reset, latency 2.
    do_reset(2);
    set_req(0, 0, 32'h10, 0, 4'hF);
    @(negedge clk); chk("t38_ready", m0_ready, 1);
    @(posedge clk); #1 m0_valid = 0;
    @(negedge clk); chk("t38_mem_en", mem_en, 1); chk("t38_mem_addr", mem_addr, 32'h10);
    @(negedge clk); chk("t38_resp", m0_resp, 1); chk("t38_rdata", m0_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Partial byte-enable write, then read back.
    run_txn(0, 1, 32'h20, 32'hAABBCCDD, 4'h3, rd, lat, h);
    chk("t41_wr_rdata", rd, 0);
    chk("t41_wr_lat", lat, 2);
    run_txn(0, 0, 32'h20, 0, 4'hF, rd, lat, h);
    chk("t41_rd_rdata", rd, 32'h1122CCDD);

    // m1 waits while m0 is busy; accepted in the next IDLE with its fields intact.
    set_req(0, 0, 32'h10, 0, 4'hF);
    @(negedge clk); chk("t43_m0_ready", m0_ready, 1);
    @(posedge clk); #1;
    m0_valid = 0;
    set_req(1, 1, 32'h24, 32'h5A5A5A5A, 4'hC);
    k = 0;
    while (k < 10) begin
      @(negedge clk); k++;
      if (m1_ready) break;
    end
    chk("t43_wait_cycles", k, 3);
    @(posedge clk); #1 m1_valid = 0;
    @(negedge clk);
    chk("t43_mem_addr", mem_addr, 32'h24);
    chk("t43_mem_wdata", mem_wdata, 32'h5A5A5A5A);
    chk("t43_mem_be", mem_be, 4'hC);
    chk("t43_mem_we", mem_we, 1);
    repeat (2) @(posedge clk); #1;

    // Reset in the ISSUE cycle of a halt write abandons it.
    do_reset(1);
    set_req(0, 1, HA, 32'h7, 4'hF);
    @(negedge clk); chk("t42_ready", m0_ready, 1);
    @(posedge clk); #1;
    m0_valid = 0;
    reset = 1;
    @(negedge clk);
    chk("t42_mem_en", mem_en, 0);
    chk("t42_halt", halt, 0);
    @(posedge clk); #1 reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t42_no_resp", m0_resp, 0);
      chk("t42_no_mem_en", mem_en, 0);
      chk("t42_halt_low", halt, 0);
    end
    @(posedge clk); #1;

    // Halt write by m1, then read of the halt address by m0.
    run_txn(1, 1, HA, 32'h1, 4'hF, rd, lat, h);
    chk("t40_halt_issue", h, 1);
    chk("t40_halt_after", halt, 1);
    run_txn(0, 0, HA, 0, 4'hF, rd, lat, h);
    chk("t40_rd_rdata", rd, 32'h1);
    chk("t40_halt_sticky", halt, 1);

    // Random traffic with occasional drops and resets.
    pend0 = 0; pend1 = 0; rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) reset = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1; rst_cnt = 1;
        pend0 = 0; pend1 = 0; m0_valid = 0; m1_valid = 0;
      end
      if (!reset) begin
        if (acc0) begin pend0 = 0; m0_valid = 0; end
        if (acc1) begin pend1 = 0; m1_valid = 0; end
        if (!pend0 && $urandom_range(0, 2) == 0) begin pend0 = 1; rand_req(0); end
        else if (pend0 && $urandom_range(0, 15) == 0) begin pend0 = 0; m0_valid = 0; end
        if (!pend1 && $urandom_range(0, 2) == 0) begin pend1 = 1; rand_req(1); end
        else if (pend1 && $urandom_range(0, 15) == 0) begin pend1 = 0; m1_valid = 0; end
      end
    end
    m0_valid = 0; m1_valid = 0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width.
REQ-002 Parameter DATA_W, default 32, data width; byte enables are DATA_W/8 wide.
REQ-003 Parameter HALT_ADDR, default 7777, simulation halt address.
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mX_valid  input  1  request from master X (X=0 core LSU, X=1 loader/debug).
REQ-008 mX_we  input  1  1=write, 0=read.
REQ-009 mX_addr  input  ADDR_W  byte address.
REQ-010 mX_wdata  input  DATA_W  write data.
REQ-011 mX_be  input  DATA_W/8  byte enables.
REQ-012 mX_ready  output  1  request accepted this cycle.
REQ-013 mX_resp  output  1  one-cycle completion pulse, read or write.
REQ-014 mX_rdata  output  DATA_W  read data, valid only while mX_resp=1.
REQ-015 mem_en, mem_we  output  1 each  memory strobe and write select.
REQ-016 mem_addr, mem_wdata, mem_be  output  ADDR_W, DATA_W, DATA_W/8  memory request fields.
REQ-017 mem_rdata  input  DATA_W  read data, valid the cycle after mem_en.
REQ-018 halt  output  1  sticky; set by a write to HALT_ADDR.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, RESP; one transaction in flight at most.
REQ-020 IDLE: if any mX_valid, pick a winner, pulse its mX_ready, register we/addr/wdata/be and winner ID, go to ISSUE. Otherwise stay in IDLE.
REQ-021 ISSUE: drive mem_en=1 with the registered fields for exactly one cycle, then go to RESP.
REQ-022 RESP: pulse the winner's mX_resp and drive mem_rdata onto mX_rdata for reads, then go to IDLE.
REQ-023 Accept-to-resp latency SHALL be 2 cycles; accepts occur only in IDLE, giving 1 transaction per 3 cycles.
REQ-024 Arbitration SHALL be round-robin. With both valid, grant the master not granted last; with one valid, grant it.
REQ-025 last_grant SHALL update only on accept.
REQ-026 mX_ready SHALL never be asserted for both masters, and SHALL be 0 outside IDLE.
REQ-027 A master SHALL hold valid and its fields stable until ready. A valid dropped before ready is a no-op.
REQ-028 mem_en=0 outside ISSUE; mem_* fields SHALL be held at the last registered value.
REQ-029 An accepted write with addr==HALT_ADDR from either master SHALL set halt in the ISSUE cycle. The write itself is still performed.
REQ-030 Once set, halt SHALL clear only by reset. A read of HALT_ADDR SHALL NOT set halt.
REQ-031 mX_rdata for a write response SHALL be 0. Address and byte enables pass through unmodified; no alignment checks.

Reset
REQ-032 Reset SHALL force state IDLE, last_grant=1 (m0 wins the first tie), halt=0, and all ready/resp/mem_en=0.
REQ-033 Reset SHALL clear mem_* fields and mX_rdata to 0.
REQ-034 Reset mid-transaction SHALL abandon it: no resp issued, no further mem_en.
REQ-035 First accept SHALL be possible in the first IDLE cycle after reset deasserts.

Structure
REQ-036 Shared package rv32_mem_pkg SHALL hold the FSM state enum, the HALT_ADDR default and the master ID type.
REQ-037 The 2-way round-robin pick SHALL be one combinational sub-module, dmem_rr_pick (inputs valid[1:0], last_grant; output grant ID), instantiated once.

Verification
REQ-038 Reset release, m0 read addr 0x10, memory holds 0xDEADBEEF -> m0_ready at T, mem_en at T+1, m0_resp with rdata 0xDEADBEEF at T+2.
REQ-039 m0 and m1 valid together for 6 transactions -> grant order m0,m1,m0,m1,m0,m1; never dual ready.
REQ-040 m1 write addr 7777, data 0x1, be 0xF -> memory written, halt=1 from the ISSUE cycle; later m0 read of 7777 returns 0x1 and halt stays 1.
REQ-041 m0 write addr 0x20, be 0x3, data 0xAABBCCDD, then read -> only the low 2 bytes change; write resp rdata=0.
REQ-042 Reset asserted during ISSUE -> no mX_resp, mem_en=0 next cycle, state IDLE, halt=0.
REQ-043 m1 valid held 3 cycles while m0 is busy -> m1 is accepted in the next IDLE with fields unchanged.
